ecc_ladder_seq: RTL and testbench

Parametrised successor to the single-core point-multiplication top. It accepts a scalar k over a W-bit word-serial bus and finds its leading one. It then sequences one Montgomery-ladder core through INIT / STEP / FINAL commands, issuing per-bit swap controls and supervising each command with a watchdog. Finally it streams the projective result back out over a W-bit valid/ready bus.

---
 rtl/ecc_ladder_seq.sv | 189 ++++++++++++++++++
 tb/tb_ecc_ladder_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_ladder_seq.sv
// Montgomery-ladder sequencer: loads scalar k, finds its leading one, drives INIT/STEP/FINAL
// core commands under a watchdog, then streams the result out. Macro ECC_SEPARATE_DY_EN adds the Z stream.
module ecc_ladder_seq #(
    parameter int M      = 163,
    parameter int W      = 32,
    parameter int TO_CYC = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         core_cmd_valid,
    output logic [1:0]   core_cmd_op,
    output logic         core_swap1,
    output logic         core_swap2,
    input  logic         core_done,
    input  logic [M-1:0] core_x,
    input  logic [M-1:0] core_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         done,
    output logic         inf,
    output logic         err
);
    localparam int NW = (M + W - 1) / W;
`ifdef ECC_SEPARATE_DY_EN
    localparam int NOUT = 2 * NW;
`else
    localparam int NOUT = NW;
`endif
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = $clog2(NOUT + 1);
    localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCAN, S_INIT, S_STEP, S_FINAL, S_UNLOAD
    } state_t;

    state_t            r_state, w_state_next;
    logic [M-1:0]      r_k, r_rx;
    logic [IW-1:0]     r_i;
    logic [CW-1:0]     r_wcnt;
    logic [TW-1:0]     r_wd;
    logic              r_cmd_valid, r_done, r_inf, r_err;
    logic              w_in_cmd, w_ack, w_wd_hit, w_issue, w_k_bit, w_scan_zero;
    logic              w_load_beat, w_load_last, w_out_beat, w_out_last;
    logic [IW-1:0]     w_ip1;
    logic [NOUT*W-1:0] w_res;
`ifdef ECC_SEPARATE_DY_EN
    logic [M-1:0]      r_rz;
`else
    // Z coordinate is only consumed when its output stream is enabled.
    logic              w_unused_z;
    assign w_unused_z = ^core_z;
`endif

    assign w_in_cmd    = (r_state inside {S_INIT, S_STEP, S_FINAL});
    // A completion coincident with our own pulse belongs to no command of ours.
    assign w_ack       = w_in_cmd && core_done && !r_cmd_valid;
    assign w_wd_hit    = w_in_cmd && !w_ack && (r_wd == TW'(TO_CYC - 1));
    assign w_k_bit     = r_k[r_i];
    assign w_ip1       = r_i + IW'(1);
    assign w_scan_zero = (r_state == S_SCAN) && !w_k_bit && (r_i == '0);
    assign w_load_beat = (r_state == S_LOAD) && in_valid;
    assign w_load_last = w_load_beat && (r_wcnt == CW'(NW - 1));
    assign w_out_beat  = (r_state == S_UNLOAD) && out_ready;
    assign w_out_last  = (r_wcnt == CW'(NOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_state_next = r_state;
        w_issue      = 1'b0;
        unique case (r_state)
            S_IDLE:   if (start) w_state_next = S_LOAD;
            S_LOAD:   if (w_load_last) w_state_next = S_SCAN;
            S_SCAN: begin
                if (w_k_bit) begin
                    w_state_next = S_INIT;
                    w_issue      = 1'b1;
                end else if (r_i == '0) begin
                    w_state_next = S_UNLOAD;
                end
            end
            // INIT holds i = lead, STEP holds the current bit; both finish at i = 0.
            S_INIT, S_STEP: begin
                if (w_ack) begin
                    w_state_next = (r_i == '0) ? S_FINAL : S_STEP;
                    w_issue      = 1'b1;
                end else if (w_wd_hit) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FINAL: begin
                if (w_ack)         w_state_next = S_UNLOAD;
                else if (w_wd_hit) w_state_next = S_IDLE;
            end
            S_UNLOAD: if (w_out_beat && w_out_last) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: operand/result registers are reset too, so an aborted job leaves no stale data.
            r_k         <= '0;
            r_rx        <= '0;
`ifdef ECC_SEPARATE_DY_EN
            r_rz        <= '0;
`endif
            r_i         <= '0;
            r_wcnt      <= '0;
            r_wd        <= '0;
            r_cmd_valid <= 1'b0;
            r_done      <= 1'b0;
            r_inf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_cmd_valid <= w_issue;
            r_done      <= w_out_beat && w_out_last;
            if (w_issue)
                r_wd <= '0;
            else if (w_in_cmd && r_wd != TW'(TO_CYC - 1))
                r_wd <= r_wd + TW'(1);
            if (r_state == S_IDLE && start) begin
                r_err  <= 1'b0;
                r_inf  <= 1'b0;
                r_wcnt <= '0;
            end
            if (w_wd_hit) r_err <= 1'b1;
            if (w_load_beat) begin
                for (int b = 0; b < M; b++)
                    if (b / W == int'(r_wcnt)) r_k[b] <= in_data[b % W];
                r_wcnt <= w_load_last ? '0 : r_wcnt + CW'(1);
            end
            if (w_out_beat) r_wcnt <= w_out_last ? '0 : r_wcnt + CW'(1);
            if (w_load_last)
                r_i <= IW'(M - 1);
            else if (r_state == S_SCAN && !w_k_bit && r_i != '0)
                r_i <= r_i - IW'(1);
            else if (w_ack && r_state != S_FINAL && r_i != '0)
                r_i <= r_i - IW'(1);
            if (w_scan_zero) begin
                r_inf <= 1'b1;
                r_rx  <= '0;
`ifdef ECC_SEPARATE_DY_EN
                r_rz  <= '0;
`endif
            end
            if (w_ack && r_state == S_FINAL) begin
                r_rx <= core_x;
`ifdef ECC_SEPARATE_DY_EN
                r_rz <= core_z;
`endif
            end
        end
    end

    always_comb begin
        w_res        = '0;
        w_res[M-1:0] = r_rx;
`ifdef ECC_SEPARATE_DY_EN
        w_res[NW*W +: M] = r_rz;
`endif
    end

    assign in_ready       = (r_state == S_LOAD);
    assign busy           = (r_state != S_IDLE);
    assign core_cmd_valid = r_cmd_valid;
    assign core_cmd_op    = (r_state == S_STEP)  ? 2'b01 :
                            (r_state == S_FINAL) ? 2'b10 : 2'b00;
    assign core_swap2     = (r_state == S_STEP) && w_k_bit;
    assign core_swap1     = (r_state == S_STEP) && (w_k_bit ^ r_k[w_ip1]);
    assign out_valid      = (r_state == S_UNLOAD);
    assign out_last       = (r_state == S_UNLOAD) && w_out_last;
    assign out_data       = (r_state == S_UNLOAD) ? w_res[int'(r_wcnt)*W +: W] : '0;
    assign done           = r_done;
    assign inf            = r_inf;
    assign err            = r_err;
endmodule

// File: tb/tb_ecc_ladder_seq.sv
// Self-checking bench for ecc_ladder_seq: behavioural core, scoreboard of result words,
// watchdog, backpressure and mid-job reset scenarios.
module tb_ecc_ladder_seq;
    localparam int M      = 163;
    localparam int W      = 32;
    localparam int TO_CYC = 4096;
    localparam int NW     = (M + W - 1) / W;
    localparam int KW     = NW * W;
`ifdef ECC_SEPARATE_DY_EN
    localparam int NOUT = 2 * NW;
`else
    localparam int NOUT = NW;
`endif

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, core_cmd_valid, core_swap1, core_swap2, core_done;
    logic out_valid, out_ready, out_last, busy, done, inf, err;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   core_cmd_op;
    logic [M-1:0] core_x, core_z;
    logic [63:0]  outs;

    ecc_ladder_seq #(.M(M), .W(W), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_cmd_valid(core_cmd_valid), .core_cmd_op(core_cmd_op),
        .core_swap1(core_swap1), .core_swap2(core_swap2),
        .core_done(core_done), .core_x(core_x), .core_z(core_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .inf(inf), .err(err)
    );

    always #5 clk = ~clk;

    assign outs = {20'b0, in_ready, core_cmd_valid, core_cmd_op, core_swap1, core_swap2,
                   out_valid, out_data, out_last, busy, done, inf, err};

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n_done  = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) n_done <= n_done + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural core: answers each command after 1..3 cycles unless a STEP stall is requested.
    logic [M-1:0] m_k;
    int  m_lead, m_i;
    int  n_pulse = 0, n_init = 0, n_step = 0, n_final = 0;
    int  cyc_init, cyc_stall, cyc_scan0;
    bit  stall_step = 1'b0;
    logic [1:0] sw_exp, op;
    initial begin
        core_done = 1'b0;
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (rst && core_cmd_valid) begin
                n_pulse++;
                op = core_cmd_op;
                case (op)
                    2'b00: begin n_init++; cyc_init = cyc; m_i = m_lead - 1; end
                    2'b01: begin
                        n_step++;
                        if (m_i >= 0 && m_i <= M - 2) begin
                            sw_exp = {m_k[m_i] ^ m_k[m_i+1], m_k[m_i]};
                            check("swap", {62'b0, core_swap1, core_swap2}, {62'b0, sw_exp});
                        end else begin
                            check("step_index", m_i, 0);
                        end
                        m_i--;
                    end
                    2'b10: n_final++;
                    default: check("cmd_op", op, 0);
                endcase
                if (stall_step && op == 2'b01) begin
                    cyc_stall = cyc;
                end else begin
                    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
                    if (rst && op == 2'b01)
                        check("swap_hold", {62'b0, core_swap1, core_swap2}, {62'b0, sw_exp});
                    core_done = 1'b1;
                    if (op == 2'b10) begin
                        @(negedge clk);
                        core_done = 1'b0;
                        check("ov_after_final", out_valid, 1);
                    end
                end
            end
        end
    end

    // Result sink: optional 1-0-0-1 backpressure, scoreboard pop on every handshake.
    bit   bp_en = 1'b0;
    int   bp_ph = 0, n_words = 0;
    bit   stalled = 1'b0;
    logic [W-1:0] stall_data;
    exp_t e;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (stalled) begin
                check("bp_valid_held", out_valid, 1);
                check("bp_data_held", out_data, stall_data);
            end
            if (bp_en) begin
                out_ready = (bp_ph == 0 || bp_ph == 3);
                bp_ph     = (bp_ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
            stalled = 1'b0;
            if (rst && out_valid) begin
                if (out_ready) begin
                    n_words++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", out_data, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.d);
                        check("out_last", out_last, e.l);
                    end
                end else begin
                    stalled    = 1'b1;
                    stall_data = out_data;
                end
            end
        end
    end

    int base_init, base_step, base_final, base_words;

    task automatic start_job(input logic [M-1:0] k, input logic [M-1:0] cx, input logic [M-1:0] cz,
                             input logic [KW-1:0] junk, input int abort_at);
        logic [KW-1:0] ex, kw;
        exp_t x;
        int t;
        m_lead = -1;
        for (int b = M - 1; b >= 0; b--)
            if (k[b] && m_lead < 0) m_lead = b;
        m_k    = k;
        core_x = cx;
        core_z = cz;
        ex = '0;
        if (m_lead >= 0) ex[M-1:0] = cx;
        for (int j = 0; j < NW; j++) begin
            x.d = ex[j*W +: W];
            x.l = (j == NOUT - 1);
            exp_q.push_back(x);
        end
`ifdef ECC_SEPARATE_DY_EN
        ex = '0;
        if (m_lead >= 0) ex[M-1:0] = cz;
        for (int j = 0; j < NW; j++) begin
            x.d = ex[j*W +: W];
            x.l = (NW + j == NOUT - 1);
            exp_q.push_back(x);
        end
`endif
        base_init = n_init; base_step = n_step; base_final = n_final; base_words = n_words;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", in_ready, 1);
        check("err_cleared_by_start", err, 0);
        kw = junk;
        kw[M-1:0] = k;
        for (int j = 0; j < NW; j++) begin
            in_valid = 1'b1;
            in_data  = kw[j*W +: W];
            if (j == abort_at) begin
                rst = 1'b0;
                return;
            end
            t = 0;
            while (!in_ready && t < 100) begin @(negedge clk); t++; end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        cyc_scan0 = cyc;
    endtask

    task automatic finish_job();
        int t;
        t = 0;
        while (!done && t < 20000) begin @(negedge clk); t++; end
        check("done_seen", done, 1);
        if (done) begin
            check("inf", inf, m_lead < 0);
            check("busy_at_done", busy, 0);
            check("word_count", n_words - base_words, NOUT);
            check("scoreboard_empty", exp_q.size(), 0);
            check("n_init", n_init - base_init, m_lead >= 0);
            check("n_step", n_step - base_step, (m_lead > 0) ? m_lead : 0);
            check("n_final", n_final - base_final, m_lead >= 0);
            if (m_lead >= 0) check("scan_cycles", cyc_init - cyc_scan0, M - m_lead);
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end
    endtask

    function automatic logic [M-1:0] rand_k();
        logic [KW-1:0] r;
        for (int j = 0; j < NW; j++) r[j*W +: W] = $urandom;
        return r[M-1:0];
    endfunction

    logic [M+7:0]  pat;
    logic [M-1:0]  k_big;
    logic [KW-1:0] junk;
    int t, snap_p, snap_w, snap_d;

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        core_x = '0; core_z = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_outputs", outs, 0);

        // k = 1: full-length scan, INIT then FINAL, 5A..A5 pattern streamed back.
        pat = '0;
        for (int b = 0; b < (M + 7) / 8; b++) pat[b*8 +: 8] = 8'h5A;
        pat[7:0] = 8'hA5;
        start_job(163'd1, pat[M-1:0], ~pat[M-1:0], '0, -1);
        finish_job();

        // k = 2^162 + 1 with junk above bit M, under backpressure.
        bp_en = 1'b1;
        junk = '1;
        k_big = '0; k_big[M-1] = 1'b1; k_big[0] = 1'b1;
        start_job(k_big, rand_k(), rand_k(), junk, -1);
        finish_job();

        // k = 0 (upper junk must be discarded): point at infinity, zero words.
        start_job('0, rand_k(), rand_k(), junk, -1);
        finish_job();
        bp_en = 1'b0;

        start_job(rand_k(), rand_k(), rand_k(), '0, -1);
        finish_job();

        // Watchdog: the core never answers the first STEP.
        stall_step = 1'b1;
        snap_d = n_done;
        start_job(163'h2D, rand_k(), rand_k(), '0, -1);
        t = 0;
        while (!err && t < TO_CYC + 200) begin @(negedge clk); t++; end
        check("wd_err", err, 1);
        if (err) check("wd_cycles", cyc - cyc_stall, TO_CYC);
        check("wd_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("wd_no_done", n_done - snap_d, 0);
        check("wd_no_words", n_words - base_words, 0);
        stall_step = 1'b0;
        exp_q.delete();

        start_job(163'd3, rand_k(), rand_k(), '0, -1);
        finish_job();

        // Reset during STEP 40.
        k_big = rand_k(); k_big[M-1] = 1'b1;
        start_job(k_big, rand_k(), rand_k(), '0, -1);
        t = 0;
        while (n_step - base_step < 40 && t < 5000) begin @(negedge clk); t++; end
        check("reached_step40", n_step - base_step, 40);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_step_outputs", outs, 0);
        snap_p = n_pulse; snap_w = n_words;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_pulse", n_pulse - snap_p, 0);
        check("rst_no_words", n_words - snap_w, 0);
        check("rst_idle", busy, 0);
        exp_q.delete();

        // Reset coincident with load beat 3.
        start_job(rand_k(), rand_k(), rand_k(), '0, 3);
        @(negedge clk);
        check("rst_in_load_outputs", outs, 0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_load_idle", busy, 0);
        exp_q.delete();

        start_job(rand_k(), rand_k(), rand_k(), '0, -1);
        finish_job();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
